// File: rtl/data_memory_pipelined_if.sv
// data_memory_pipelined_if
//   Request/response bus between the MEM stage (master) and the data memory
//   (slave).
//   req_valid/req_ready   request handshake; transfer on valid && ready
//   req_we                1 = store, 0 = load
//   req_size              0 = B, 1 = H, 2 = W, 3 = D
//   req_unsigned          loads: 1 = zero-extend, 0 = sign-extend
//   req_addr              byte address
//   req_wdata             right-justified store data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             extended load data (0 for stores and errors)
//   rsp_err               access fault
interface data_memory_pipelined_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_pipelined.sv
// data_memory_pipelined
//   Byte-addressable data memory (2**ADDR_WIDTH bytes) for the pipelined core.
//   Loads/stores of B/H/W/D with byte-lane writes and sign/zero extension,
//   READ_LATENCY response stages, responses honour backpressure.
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset (clears the response pipeline only)
//   bus   data_memory_pipelined_if.slave (request/response handshake)
// Build option
//   DMEM_MISALIGN_TRAP_EN  defined: misaligned accesses respond with rsp_err
//                          and never write; undefined: the address is masked
//                          to the natural alignment of the access.
module data_memory_pipelined #(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned READ_LATENCY = 1
) (
    input logic                    clk,
    input logic                    rst,
    data_memory_pipelined_if.slave bus
);
    localparam int unsigned MEM_BYTES = 2 ** ADDR_WIDTH;
    localparam int unsigned NB        = DATA_WIDTH / 8;

    logic [7:0] mem_q [MEM_BYTES];

    logic                  stall;
    logic                  accept;
    logic                  wr_en;
    logic                  illegal;
    logic                  acc_err;
    logic                  msb;
    logic                  sign_bit;
    logic [3:0]            size_bytes;
    logic [6:0]            nbits;
    logic [ADDR_WIDTH-1:0] lane_mask;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [DATA_WIDTH-1:0] raw;
    logic [DATA_WIDTH-1:0] ext;

    logic                  s0_vld_d;
    logic                  s0_err_d;
    logic [DATA_WIDTH-1:0] s0_data_d;

    logic                  vld_q  [READ_LATENCY];
    logic                  err_q  [READ_LATENCY];
    logic [DATA_WIDTH-1:0] data_q [READ_LATENCY];

    // A held response freezes the whole pipeline and blocks new requests.
    assign stall         = bus.rsp_valid && !bus.rsp_ready;
    assign bus.req_ready = !rst && !stall;
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        size_bytes = 4'd1 << bus.req_size;
        lane_mask  = ADDR_WIDTH'(size_bytes - 4'd1);
        base_addr  = bus.req_addr & ~lane_mask;
        illegal    = (DATA_WIDTH == 32) && (bus.req_size == 2'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
        acc_err    = illegal || (|(bus.req_addr & lane_mask));
`else
        acc_err    = illegal;
`endif
    end

    // Gather a full bus width starting at the aligned address; the index
    // wraps inside the array and bytes beyond the access size are discarded.
    for (genvar g = 0; g < NB; g++) begin : g_rd
        assign raw[8*g +: 8] = mem_q[base_addr + ADDR_WIDTH'(g)];
    end

    always_comb begin
        case (bus.req_size)
            2'd0:    begin nbits = 7'd8;              msb = raw[7];            end
            2'd1:    begin nbits = 7'd16;             msb = raw[15];           end
            2'd2:    begin nbits = 7'd32;             msb = raw[31];           end
            default: begin nbits = 7'(DATA_WIDTH);    msb = raw[DATA_WIDTH-1]; end
        endcase
        sign_bit = msb && !bus.req_unsigned;
    end

    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_ext
        assign ext[g] = (7'(g) < nbits) ? raw[g] : sign_bit;
    end

    assign s0_vld_d  = accept;
    assign s0_err_d  = accept && acc_err;
    assign s0_data_d = (!accept || acc_err || bus.req_we) ? '0 : ext;
    assign wr_en     = accept && bus.req_we && !acc_err;

    // Array has no reset; accept already excludes reset and stall cycles.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (i < 32'(size_bytes)) begin
                    mem_q[base_addr + ADDR_WIDTH'(i)] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q[0]  <= 1'b0;
            err_q[0]  <= 1'b0;
            data_q[0] <= '0;
        end else if (!stall) begin
            vld_q[0]  <= s0_vld_d;
            err_q[0]  <= s0_err_d;
            data_q[0] <= s0_data_d;
        end
    end

    for (genvar s = 1; s < READ_LATENCY; s++) begin : g_stage
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q[s]  <= 1'b0;
                err_q[s]  <= 1'b0;
                data_q[s] <= '0;
            end else if (!stall) begin
                vld_q[s]  <= vld_q[s-1];
                err_q[s]  <= err_q[s-1];
                data_q[s] <= data_q[s-1];
            end
        end
    end

    assign bus.rsp_valid = vld_q[READ_LATENCY-1];
    assign bus.rsp_err   = err_q[READ_LATENCY-1];
    assign bus.rsp_rdata = data_q[READ_LATENCY-1];
endmodule

// File: tb/tb_data_memory_pipelined.sv
// tb_data_memory_pipelined
//   Bench for data_memory_pipelined: a 64-bit, latency-3 instance driven with
//   directed and random traffic against a byte-array reference model, plus a
//   32-bit, latency-1 instance for the illegal doubleword size.
module tb_data_memory_pipelined;
    localparam int unsigned DW  = 64;
    localparam int unsigned AW  = 10;
    localparam int unsigned LAT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_memory_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    data_memory_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) bus32 ();

    data_memory_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    data_memory_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut32 (
        .clk(clk), .rst(rst), .bus(bus32)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic rdy_dir = 1'b1;
    logic rnd_bp  = 1'b0;
    logic rnd_bit = 1'b1;
    assign bus.rsp_ready = rdy_dir && (!rnd_bp || rnd_bit);

    always @(posedge clk) begin
        #2;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: flat byte array, little-endian, natural-size accesses.
    logic [7:0] mmem [1024];

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int unsigned acc;
    } exp_t;
    exp_t exp_q[$];

    function automatic void model_accept(input logic we, input logic [1:0] size, input logic uns,
                                         input int unsigned addr, input logic [63:0] wdata,
                                         output logic [63:0] rd, output logic err);
        int unsigned nb   = 1 << size;
        int unsigned base = addr - (addr % nb);
        logic [63:0] v    = 64'd0;
        rd  = 64'd0;
        err = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (addr % nb != 0) err = 1'b1;
`endif
        if (err) return;
        if (we) begin
            for (int i = 0; i < int'(nb); i++) mmem[base + i] = 8'(wdata >> (8 * i));
        end else begin
            for (int i = 0; i < int'(nb); i++) v = v | (64'(mmem[base + i]) << (8 * i));
            if (nb < 8 && !uns && v[8*nb-1]) v = v | (~64'd0 << (8 * nb));
            rd = v;
        end
    endfunction

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        prev_stall = 1'b0;
    logic [63:0] prev_rd;
    logic        prev_err;
    logic [63:0] last_rdata = 64'd0;
    logic        last_err   = 1'b0;
    int unsigned last_lat   = 0;
    int unsigned rsp_cnt    = 0;
    int unsigned stall_cnt  = 0;
    exp_t        mon_e;
    exp_t        new_e;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(bus.rsp_valid), 64'd1);
                check("hold_rdata", bus.rsp_rdata, prev_rd);
                check("hold_err", 64'(bus.rsp_err), 64'(prev_err));
            end
            prev_stall = bus.rsp_valid && !bus.rsp_ready;
            prev_rd    = bus.rsp_rdata;
            prev_err   = bus.rsp_err;
            if (prev_stall) begin
                stall_cnt++;
                check("stall_req_ready", 64'(bus.req_ready), 64'd0);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                    check("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
                    last_rdata = bus.rsp_rdata;
                    last_err   = bus.rsp_err;
                    last_lat   = cyc + 1 - mon_e.acc;
                    check("min_latency", 64'(last_lat >= LAT), 64'd1);
                    rsp_cnt++;
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                model_accept(bus.req_we, bus.req_size, bus.req_unsigned, 32'(bus.req_addr),
                             bus.req_wdata, new_e.rdata, new_e.err);
                new_e.acc = cyc + 1;
                exp_q.push_back(new_e);
            end
        end
    end

    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [AW-1:0] addr, input logic [63:0] wdata);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                @(posedge clk); #2;
                return;
            end
            @(posedge clk); #2;
        end
        check("req_accept_timeout", 64'(bus.req_ready), 64'd1);
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) check(tag, 64'(exp_q.size()), 64'd0);
        @(posedge clk); #2;
    endtask

    task automatic t32(input string tag, input logic we, input logic [1:0] size, input logic uns,
                       input logic [AW-1:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err);
        bit got = 1'b0;
        bus32.req_valid    = 1'b1;
        bus32.req_we       = we;
        bus32.req_size     = size;
        bus32.req_unsigned = uns;
        bus32.req_addr     = addr;
        bus32.req_wdata    = wdata;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (bus32.req_ready) got = 1'b1;
            @(posedge clk); #2;
        end
        bus32.req_valid = 1'b0;
        if (!got) check({tag, "_accept"}, 64'(bus32.req_ready), 64'd1);
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (bus32.rsp_valid) begin
                got = 1'b1;
                check({tag, "_rdata"}, 64'(bus32.rsp_rdata), 64'(exp_rd));
                check({tag, "_err"}, 64'(bus32.rsp_err), 64'(exp_err));
            end
            @(posedge clk); #2;
        end
        if (!got) check({tag, "_rsp_timeout"}, 64'(bus32.rsp_valid), 64'd1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: run did not complete, tests_run=%0d", tests_run);
        $fatal(1);
    end

    initial begin
        int unsigned c0;
        int unsigned s0;
        for (int i = 0; i < 1024; i++) mmem[i] = 8'h00;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus32.req_valid = 1'b0; bus32.req_we = 1'b0; bus32.req_size = 2'd0;
        bus32.req_unsigned = 1'b0; bus32.req_addr = '0; bus32.req_wdata = '0;
        bus32.rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        @(negedge clk);
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 64'd0);
        check("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("reset_req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_req_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #2;

        // Known contents for the low window used by random traffic
        for (int a = 0; a < 256; a += 8) send(1'b1, 2'd3, 1'b0, AW'(a), 64'd0);
        idle();
        drain("init_drain");

        // Store then load, back-to-back
        send(1'b1, 2'd3, 1'b0, 10'h010, 64'h8877665544332211);
        send(1'b0, 2'd0, 1'b0, 10'h017, 64'd0);
        idle(); drain("lb_drain");
        check("lb_signed", last_rdata, 64'hFFFF_FFFF_FFFF_FF88);
        send(1'b0, 2'd0, 1'b1, 10'h017, 64'd0);
        idle(); drain("lbu_drain");
        check("lbu", last_rdata, 64'h0000_0000_0000_0088);
        send(1'b0, 2'd1, 1'b0, 10'h016, 64'd0);
        idle(); drain("lh_drain");
        check("lh_signed", last_rdata, 64'hFFFF_FFFF_FFFF_8877);

        // Byte lanes
        send(1'b1, 2'd3, 1'b0, 10'h020, 64'd0);
        send(1'b1, 2'd0, 1'b0, 10'h023, 64'hFFFF_FFFF_FFFF_FFAB);
        send(1'b0, 2'd3, 1'b0, 10'h020, 64'd0);
        idle(); drain("lane_drain");
        check("sb_lane", last_rdata, 64'h0000_0000_AB00_0000);
        send(1'b1, 2'd3, 1'b0, 10'h028, 64'hFFFF_FFFF_FFFF_FFFF);
        send(1'b1, 2'd1, 1'b0, 10'h02C, 64'h1234_5678_9ABC_0000);
        send(1'b0, 2'd3, 1'b0, 10'h028, 64'd0);
        idle(); drain("sh_lane_drain");
        check("sh_lane", last_rdata, 64'hFFFF_0000_FFFF_FFFF);

        // Latency with no backpressure
        send(1'b0, 2'd3, 1'b0, 10'h010, 64'd0);
        idle(); drain("lat_drain");
        check("latency", 64'(last_lat), 64'(LAT));
        check("ld_data", last_rdata, 64'h8877665544332211);

        // Backpressure: 4 back-to-back loads, 2 stalled cycles after the first response
        c0 = rsp_cnt;
        s0 = stall_cnt;
        send(1'b0, 2'd3, 1'b0, 10'h010, 64'd0);
        send(1'b0, 2'd3, 1'b0, 10'h020, 64'd0);
        send(1'b0, 2'd3, 1'b0, 10'h028, 64'd0);
        send(1'b0, 2'd2, 1'b0, 10'h014, 64'd0);
        idle();
        rdy_dir = 1'b0;
        @(negedge clk);
        check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("bp_req_ready", 64'(bus.req_ready), 64'd0);
        check("bp_rdata_2nd", bus.rsp_rdata, 64'h0000_0000_AB00_0000);
        @(posedge clk); #2;
        @(negedge clk);
        check("bp_req_ready2", 64'(bus.req_ready), 64'd0);
        check("bp_rdata_held", bus.rsp_rdata, 64'h0000_0000_AB00_0000);
        @(posedge clk); #2;
        rdy_dir = 1'b1;
        drain("bp_drain");
        check("bp_rsp_count", 64'(rsp_cnt - c0), 64'd4);
        check("bp_stall_cycles", 64'(stall_cnt - s0), 64'd2);
        check("bp_last_in_order", last_rdata, 64'hFFFF_FFFF_8877_6655);

        // Misaligned access
        send(1'b1, 2'd2, 1'b0, 10'h000, 64'h0000_0000_DEAD_BEEF);
        send(1'b0, 2'd2, 1'b0, 10'h002, 64'd0);
        idle(); drain("mis_lw_drain");
`ifdef DMEM_MISALIGN_TRAP_EN
        check("mis_lw_err", 64'(last_err), 64'd1);
        check("mis_lw_rdata", last_rdata, 64'd0);
`else
        check("mis_lw_err", 64'(last_err), 64'd0);
        check("mis_lw_rdata", last_rdata, 64'hFFFF_FFFF_DEAD_BEEF);
`endif
        send(1'b1, 2'd2, 1'b0, 10'h041, 64'h0000_0000_1234_5678);
        send(1'b0, 2'd2, 1'b1, 10'h040, 64'd0);
        idle(); drain("mis_sw_drain");
`ifdef DMEM_MISALIGN_TRAP_EN
        check("mis_sw_nowrite", last_rdata, 64'd0);
`else
        check("mis_sw_masked", last_rdata, 64'h0000_0000_1234_5678);
`endif

        // Top of memory
        send(1'b1, 2'd3, 1'b0, 10'h3F8, 64'h0123_4567_89AB_CDEF);
        send(1'b0, 2'd0, 1'b0, 10'h3FF, 64'd0);
        idle(); drain("top_drain");
        check("top_lb", last_rdata, 64'h0000_0000_0000_0001);
        send(1'b0, 2'd3, 1'b0, 10'h3F8, 64'd0);
        idle(); drain("top_ld_drain");
        check("top_ld", last_rdata, 64'h0123_4567_89AB_CDEF);

        // Random traffic with random backpressure
        rnd_bp = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle();
                @(posedge clk); #2;
            end else begin
                send(1'(($urandom_range(0, 2)) == 0), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)),
                     {$urandom, $urandom});
            end
        end
        idle();
        rnd_bp = 1'b0;
        drain("rand_drain");

        // Reset mid-traffic
        send(1'b0, 2'd3, 1'b0, 10'h010, 64'd0);
        send(1'b0, 2'd3, 1'b0, 10'h020, 64'd0);
        send(1'b0, 2'd3, 1'b0, 10'h028, 64'd0);
        idle();
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #2;
            check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            check("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_release_ready", 64'(bus.req_ready), 64'd1);
        repeat (6) begin
            check("no_stale_rsp", 64'(bus.rsp_valid), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #2;
        send(1'b0, 2'd3, 1'b0, 10'h3F8, 64'd0);
        idle(); drain("post_rst_drain");
        check("post_rst_mem_kept", last_rdata, 64'h0123_4567_89AB_CDEF);

        // 32-bit instance: doubleword is illegal
        t32("w32_sw", 1'b1, 2'd2, 1'b0, 10'h040, 32'h1122_3344, 32'd0, 1'b0);
        t32("w32_sd", 1'b1, 2'd3, 1'b0, 10'h040, 32'hFFFF_FFFF, 32'd0, 1'b1);
        t32("w32_lw", 1'b0, 2'd2, 1'b0, 10'h040, 32'd0, 32'h1122_3344, 1'b0);
        t32("w32_lh", 1'b0, 2'd1, 1'b0, 10'h042, 32'd0, 32'h0000_1122, 1'b0);
        t32("w32_sw2", 1'b1, 2'd2, 1'b0, 10'h044, 32'h8000_F00D, 32'd0, 1'b0);
        t32("w32_lh_neg", 1'b0, 2'd1, 1'b0, 10'h044, 32'd0, 32'hFFFF_F00D, 1'b0);
        t32("w32_lhu", 1'b0, 2'd1, 1'b1, 10'h044, 32'd0, 32'h0000_F00D, 1'b0);
        t32("w32_lw_neg", 1'b0, 2'd2, 1'b0, 10'h044, 32'd0, 32'h8000_F00D, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
